// File: rtl/obj_regfile_pkg.sv
// Shared indices, widths and helpers for the object register file.
package obj_regfile_pkg;
  localparam int DATA_W          = 32;
  localparam int REG_AW          = 5;
  localparam int NUM_REGS        = 32;
  localparam int DEF_OBJ_BASE    = 20;
  localparam int DEF_CTRL_REG    = 29;
  localparam int DEF_FRAME_REG   = 30;
  localparam int CTRL_RELOAD_BIT = 0;

  function automatic logic [REG_AW-1:0] obj_reg_idx(int base, int k, bit is_y);
    return REG_AW'(base + 2 * k + (is_y ? 1 : 0));
  endfunction
endpackage

// File: rtl/obj_regfile_if.sv
// Processor-side register bus: one write port, two combinational read ports.
interface obj_regfile_if;
  import obj_regfile_pkg::*;

  logic              ctrl_writeEnable;
  logic [REG_AW-1:0] ctrl_writeReg;
  logic [REG_AW-1:0] ctrl_readRegA;
  logic [REG_AW-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_writeReg;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/obj_regfile_frame_sync.sv
// Brings the asynchronous end-of-frame level into the clock domain and emits
// a one-cycle pulse per rising transition.
module frame_sync (
  input  logic clock,
  input  logic reset,
  input  logic screen_end_i,
  output logic frame_pulse_o
);
  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the edge-detect delay.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], screen_end_i};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign frame_pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/obj_regfile.sv
// 32x32 register file with double-buffered object coordinates committed once
// per display frame, a reload control bit and a free-running frame counter.
module obj_regfile
  import obj_regfile_pkg::*;
#(
  parameter int NUM_OBJ   = 2,
  parameter int OBJ_BASE  = DEF_OBJ_BASE,
  parameter int CTRL_REG  = DEF_CTRL_REG,
  parameter int FRAME_REG = DEF_FRAME_REG
) (
  input  logic                      clock,
  input  logic                      reset,
  obj_regfile_if.slave              bus,
  input  logic                      screenEnd,
  input  logic [NUM_OBJ*DATA_W-1:0] obj_xinit,
  input  logic [NUM_OBJ*DATA_W-1:0] obj_yinit,
  output logic [NUM_OBJ*DATA_W-1:0] obj_x,
  output logic [NUM_OBJ*DATA_W-1:0] obj_y
);
  if (NUM_OBJ < 1 || NUM_OBJ > 8 || !(OBJ_BASE + 2 * NUM_OBJ - 1 < CTRL_REG) ||
      !(CTRL_REG < FRAME_REG) || FRAME_REG > 31) begin : g_bad_params
    $error("obj_regfile: illegal NUM_OBJ/OBJ_BASE/CTRL_REG/FRAME_REG combination");
  end

  localparam logic [REG_AW-1:0] CTRL_IDX  = REG_AW'(CTRL_REG);
  localparam logic [REG_AW-1:0] FRAME_IDX = REG_AW'(FRAME_REG);

  logic [DATA_W-1:0]         regs_q [NUM_REGS];
  logic [DATA_W-1:0]         regs_d [NUM_REGS];
  logic [DATA_W-1:0]         init_val [NUM_REGS];
  logic [DATA_W-1:0]         frame_q, frame_d;
  logic [NUM_OBJ*DATA_W-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic                      frame_pulse;
  logic                      wr_ok, wr_ctrl;

  frame_sync u_frame_sync (
    .clock         (clock),
    .reset         (reset),
    .screen_end_i  (screenEnd),
    .frame_pulse_o (frame_pulse)
  );

  // Power-on / reload image: init coordinates in shadow slots, zero elsewhere.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) init_val[i] = '0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      init_val[obj_reg_idx(OBJ_BASE, k, 1'b0)] = obj_xinit[k*DATA_W +: DATA_W];
      init_val[obj_reg_idx(OBJ_BASE, k, 1'b1)] = obj_yinit[k*DATA_W +: DATA_W];
    end
  end

  assign wr_ok   = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0) &&
                   (bus.ctrl_writeReg != FRAME_IDX);
  assign wr_ctrl = wr_ok && (bus.ctrl_writeReg == CTRL_IDX);

  // A pending reload overrides any shadow write landing on the same edge.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.ctrl_writeReg] = bus.data_writeReg;
    if (regs_q[CTRL_IDX][CTRL_RELOAD_BIT]) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        regs_d[obj_reg_idx(OBJ_BASE, k, 1'b0)] = init_val[obj_reg_idx(OBJ_BASE, k, 1'b0)];
        regs_d[obj_reg_idx(OBJ_BASE, k, 1'b1)] = init_val[obj_reg_idx(OBJ_BASE, k, 1'b1)];
      end
      if (!wr_ctrl) regs_d[CTRL_IDX][CTRL_RELOAD_BIT] = 1'b0;
    end
    regs_d[0] = '0;
  end

  // Commit samples the stored shadows, so same-edge writes/reloads land next frame.
  always_comb begin
    obj_x_d = obj_x_q;
    obj_y_d = obj_y_q;
    frame_d = frame_q + DATA_W'(frame_pulse);
    if (frame_pulse) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        obj_x_d[k*DATA_W +: DATA_W] = regs_q[obj_reg_idx(OBJ_BASE, k, 1'b0)];
        obj_y_d[k*DATA_W +: DATA_W] = regs_q[obj_reg_idx(OBJ_BASE, k, 1'b1)];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q  <= init_val;
      frame_q <= '0;
      obj_x_q <= obj_xinit;
      obj_y_q <= obj_yinit;
    end else begin
      regs_q  <= regs_d;
      frame_q <= frame_d;
      obj_x_q <= obj_x_d;
      obj_y_q <= obj_y_d;
    end
  end

  always_comb begin
    bus.data_readRegA = (bus.ctrl_readRegA == FRAME_IDX) ? frame_q : regs_q[bus.ctrl_readRegA];
    bus.data_readRegB = (bus.ctrl_readRegB == FRAME_IDX) ? frame_q : regs_q[bus.ctrl_readRegB];
  end

  assign obj_x = obj_x_q;
  assign obj_y = obj_y_q;
endmodule

// File: tb/tb_obj_regfile.sv
// Directed self-checking bench for obj_regfile with two objects.
module tb_obj_regfile;
  import obj_regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        screenEnd = 1'b0;
  logic [63:0] obj_xinit = {32'd200, 32'd100};
  logic [63:0] obj_yinit = {32'd150, 32'd50};
  logic [63:0] obj_x, obj_y;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rv;

  obj_regfile_if bus ();

  obj_regfile #(.NUM_OBJ(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .screenEnd (screenEnd),
    .obj_xinit (obj_xinit),
    .obj_yinit (obj_yinit),
    .obj_x     (obj_x),
    .obj_y     (obj_y)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = idx;
    bus.data_writeReg    = val;
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] idx, output logic [31:0] val);
    bus.ctrl_readRegA = idx;
    #1;
    val = bus.data_readRegA;
  endtask

  task automatic frame();
    screenEnd = 1'b1;
    tick(3);
    screenEnd = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++;
    if (obj_x !== {32'd200, 32'd100}) begin n_fail++; $display("FAIL reset_obj_x: got %h expected %h", obj_x, {32'd200, 32'd100}); end
    n_checks++;
    if (obj_y !== {32'd150, 32'd50}) begin n_fail++; $display("FAIL reset_obj_y: got %h expected %h", obj_y, {32'd150, 32'd50}); end
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'd0) begin n_fail++; $display("FAIL reset_frame: got %0d expected 0", rv); end
    rd_a(5'd20, rv);
    n_checks++;
    if (rv !== 32'd100) begin n_fail++; $display("FAIL reset_shadow_r20: got %0d expected 100", rv); end
    rd_a(5'd29, rv);
    n_checks++;
    if (rv !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 0", rv); end
    @(negedge clock);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_shadow_commit();
    wr(5'd20, 32'd300);
    tick(3);
    n_checks++;
    if (obj_x[31:0] !== 32'd100) begin n_fail++; $display("FAIL shadow_no_leak: got %0d expected 100", obj_x[31:0]); end
    screenEnd = 1'b1;
    tick(2);
    rd_a(5'd30, rv);
    n_checks++;
    if (obj_x[31:0] !== 32'd100 || rv !== 32'd0) begin
      n_fail++; $display("FAIL commit_early: obj_x0 %0d frame %0d expected 100 / 0", obj_x[31:0], rv);
    end
    tick(1);
    rd_a(5'd30, rv);
    n_checks++;
    if (obj_x[31:0] !== 32'd300) begin n_fail++; $display("FAIL commit_obj_x0: got %0d expected 300", obj_x[31:0]); end
    n_checks++;
    if (rv !== 32'd1) begin n_fail++; $display("FAIL commit_frame: got %0d expected 1", rv); end
    n_checks++;
    if (obj_x[63:32] !== 32'd200) begin n_fail++; $display("FAIL commit_obj_x1: got %0d expected 200", obj_x[63:32]); end
    screenEnd = 1'b0;
    tick(3);
  endtask

  task automatic test_long_high();
    screenEnd = 1'b1;
    tick(50);
    screenEnd = 1'b0;
    tick(3);
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'd2) begin n_fail++; $display("FAIL long_high_frame: got %0d expected 2", rv); end
  endtask

  task automatic test_commit_edge_write();
    screenEnd = 1'b1;
    tick(2);
    wr(5'd21, 32'd77);
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'd3) begin n_fail++; $display("FAIL edge_write_frame: got %0d expected 3", rv); end
    n_checks++;
    if (obj_y[31:0] !== 32'd50) begin n_fail++; $display("FAIL edge_write_obj_y0: got %0d expected 50", obj_y[31:0]); end
    rd_a(5'd21, rv);
    n_checks++;
    if (rv !== 32'd77) begin n_fail++; $display("FAIL edge_write_shadow: got %0d expected 77", rv); end
    screenEnd = 1'b0;
    tick(3);
    frame();
    n_checks++;
    if (obj_y[31:0] !== 32'd77) begin n_fail++; $display("FAIL next_frame_obj_y0: got %0d expected 77", obj_y[31:0]); end
  endtask

  task automatic test_reload();
    wr(5'd20, 32'd555);
    wr(5'd23, 32'd999);
    wr(5'd29, 32'd5);
    rd_a(5'd29, rv);
    n_checks++;
    if (rv !== 32'd5) begin n_fail++; $display("FAIL ctrl_written: got %0d expected 5", rv); end
    tick(1);
    rd_a(5'd20, rv);
    n_checks++;
    if (rv !== 32'd100) begin n_fail++; $display("FAIL reload_r20: got %0d expected 100", rv); end
    rd_a(5'd23, rv);
    n_checks++;
    if (rv !== 32'd150) begin n_fail++; $display("FAIL reload_r23: got %0d expected 150", rv); end
    rd_a(5'd29, rv);
    n_checks++;
    if (rv !== 32'd4) begin n_fail++; $display("FAIL reload_ctrl_clear: got %0d expected 4", rv); end
    n_checks++;
    if (obj_x[31:0] !== 32'd300 || obj_y[63:32] !== 32'd150) begin
      n_fail++; $display("FAIL reload_outputs: obj_x0 %0d obj_y1 %0d expected 300 / 150", obj_x[31:0], obj_y[63:32]);
    end
    wr(5'd0, 32'd123);
    rd_a(5'd0, rv);
    n_checks++;
    if (rv !== 32'd0) begin n_fail++; $display("FAIL r0_write: got %0d expected 0", rv); end
    wr(5'd30, 32'd55);
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'd4) begin n_fail++; $display("FAIL frame_write: got %0d expected 4", rv); end
  endtask

  task automatic test_back_to_back();
    wr(5'd20, 32'd1);
    wr(5'd29, 32'd1);
    wr(5'd22, 32'd777);
    rd_a(5'd20, rv);
    n_checks++;
    if (rv !== 32'd100) begin n_fail++; $display("FAIL b2b_r20: got %0d expected 100", rv); end
    rd_a(5'd22, rv);
    n_checks++;
    if (rv !== 32'd200) begin n_fail++; $display("FAIL b2b_reload_wins: got %0d expected 200", rv); end
    wr(5'd24, 32'hDEAD_BEEF);
    bus.ctrl_readRegB = 5'd24;
    #1;
    n_checks++;
    if (bus.data_readRegB !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL general_r24: got %h expected deadbeef", bus.data_readRegB); end
    frame();
    n_checks++;
    if (obj_x !== {32'd200, 32'd100}) begin n_fail++; $display("FAIL b2b_commit: got %h expected %h", obj_x, {32'd200, 32'd100}); end
  endtask

  task automatic test_wrap();
    force dut.frame_q = 32'hFFFF_FFFF;
    tick(2);
    release dut.frame_q;
    tick(1);
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffffffff", rv); end
    frame();
    rd_a(5'd30, rv);
    n_checks++;
    if (rv !== 32'd0) begin n_fail++; $display("FAIL wrap_frame: got %h expected 0", rv); end
  endtask

  initial begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.ctrl_readRegA    = '0;
    bus.ctrl_readRegB    = '0;
    bus.data_writeReg    = '0;
    test_reset();
    test_shadow_commit();
    test_long_high();
    test_commit_edge_write();
    test_reload();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
